// File: rtl/sa_result_drain.sv
// Systolic-array result drain: snapshots the NxN accumulator plane on START and
// streams it row-major over valid/ready. The snapshot lets the array keep running.

// One snapshot word: loads on capture, otherwise holds.
module sa_drain_word #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  // Capture register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module sa_result_drain #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int IW = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [N*N*DW-1:0] C_IN,
  input  logic              CLR_ERR,
  output logic [DW-1:0]     OUT_DATA,
  output logic [IW-1:0]     OUT_ROW,
  output logic [IW-1:0]     OUT_COL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  localparam int NN = N * N;
  localparam int XW = $clog2(NN);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [NN-1:0][DW-1:0]  snap;
  logic [XW-1:0]          idx;   // flat word index, selects the snapshot word
  logic [IW-1:0]          row, col;
  logic                   load, fire, last;

  // Capture only from IDLE; START elsewhere is an error, not a restart.
  assign load = START && (state == S_IDLE);
  assign fire = OUT_VALID && OUT_READY;
  assign last = (idx == XW'(NN - 1));

  genvar g;
  generate
    for (g = 0; g < NN; g++) begin : g_word
      sa_drain_word #(.DW(DW)) u_word (
        .CLK  (CLK),
        .RST  (RST),
        .load (load),
        .d    (C_IN[g*DW +: DW]),
        .q    (snap[g])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and stream outputs; outputs are zeroed whenever no beat is offered.
  always_comb begin
    state_nxt = state;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state)
      S_IDLE:   if (load) state_nxt = S_STREAM;
      S_STREAM: begin
        OUT_VALID = 1'b1;
        BUSY      = 1'b1;
        if (fire && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    OUT_DATA = OUT_VALID ? snap[idx] : '0;
    OUT_ROW  = OUT_VALID ? row : '0;
    OUT_COL  = OUT_VALID ? col : '0;
    OUT_LAST = OUT_VALID && last;
  end

  // Beat position; row/col kept alongside the flat index to avoid a divider.
  always_ff @(posedge CLK) begin
    if (RST || load) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (fire) begin
      if (last) begin
        idx <= '0;
        row <= '0;
        col <= '0;
      end else begin
        idx <= idx + 1'b1;
        if (col == IW'(N - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Sticky error: a set in the same cycle as a clear wins.
  always_ff @(posedge CLK) begin
    if (RST)                              ERR <= 1'b0;
    else if (START && state != S_IDLE)    ERR <= 1'b1;
    else if (CLR_ERR)                     ERR <= 1'b0;
  end
endmodule

// File: tb/tb_sa_result_drain.sv
// Directed + randomized bench for sa_result_drain. A reference matrix per stream
// supplies the expected beat sequence; ERR is tracked as a sticky flag model.
module tb_sa_result_drain;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int NN = N * N;

  logic              CLK = 1'b0;
  logic              RST, START, CLR_ERR, OUT_READY;
  logic [NN*DW-1:0]  C_IN;
  logic [DW-1:0]     OUT_DATA;
  logic [IW-1:0]     OUT_ROW, OUT_COL;
  logic              OUT_VALID, OUT_LAST, BUSY, DONE, ERR;

  int vectors     = 0;
  int miscompares = 0;
  bit m_err       = 1'b0;
  logic [DW-1:0] mat [N][N];

  sa_result_drain #(.N(N), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .C_IN      (C_IN),
    .CLR_ERR   (CLR_ERR),
    .OUT_DATA  (OUT_DATA),
    .OUT_ROW   (OUT_ROW),
    .OUT_COL   (OUT_COL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack_mat();
    logic [NN*DW-1:0] p;
    p = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        p[(r*N+c)*DW +: DW] = mat[r][c];
    return p;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = DW'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(OUT_VALID), 0);
    chk({tag, "_busy"},  32'(BUSY), 0);
    chk({tag, "_done"},  32'(DONE), 0);
    chk({tag, "_last"},  32'(OUT_LAST), 0);
  endtask

  // rdy_mode: 0 always ready, 1 alternating 1010..., 2 random.
  // err_beat: pulse START while streaming word err_beat (with CLR_ERR if err_clr).
  // abort_beat: assert RST once that many beats have been accepted.
  task automatic run_stream(input int rdy_mode, input int err_beat, input bit err_clr,
                            input int abort_beat, input bit ones_after);
    int k, cyc;
    bit acc, st, cl, injected;
    k = 0; cyc = 0; injected = 0;
    @(negedge CLK);
    C_IN = pack_mat(); START = 1'b1; CLR_ERR = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK);
    if (ones_after) C_IN = '1;
    else for (int i = 0; i < NN*DW/32; i++) C_IN[i*32 +: 32] = $urandom;
    while (k < NN && cyc < 1000) begin
      START = 1'b0; CLR_ERR = 1'b0;
      case (rdy_mode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = (cyc % 2 == 0);
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
      if (k == err_beat && !injected) begin
        START = 1'b1; CLR_ERR = err_clr; injected = 1;
      end
      chk("valid", 32'(OUT_VALID), 1);
      chk("busy",  32'(BUSY), 1);
      chk("done",  32'(DONE), 0);
      chk("err",   32'(ERR), 32'(m_err));
      chk("data",  32'(OUT_DATA), 32'(mat[k/N][k%N]));
      chk("row",   32'(OUT_ROW), 32'(k / N));
      chk("col",   32'(OUT_COL), 32'(k % N));
      chk("last",  32'(OUT_LAST), 32'(k == NN - 1));
      if (k == abort_beat) begin
        RST = 1'b1; START = 1'b0; CLR_ERR = 1'b0;
        @(negedge CLK);
        RST = 1'b0; m_err = 1'b0;
        check_idle_outputs("abort");
        chk("abort_err",  32'(ERR), 0);
        chk("abort_data", 32'(OUT_DATA), 0);
        return;
      end
      acc = OUT_READY; st = START; cl = CLR_ERR;
      @(negedge CLK);
      if (st) m_err = 1'b1;
      else if (cl) m_err = 1'b0;
      if (acc) k++;
      cyc++;
    end
    chk("beats_accepted", 32'(k), NN);
    START = 1'b0; CLR_ERR = 1'b0;
    chk("done_pulse", 32'(DONE), 1);
    chk("done_valid", 32'(OUT_VALID), 0);
    chk("done_busy",  32'(BUSY), 0);
    chk("done_err",   32'(ERR), 32'(m_err));
    if (rdy_mode == 0) chk("stream_cycles", 32'(cyc), NN);
    @(negedge CLK);
    check_idle_outputs("post_done");
  endtask

  task automatic clear_err();
    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    m_err = 1'b0;
    chk("err_cleared", 32'(ERR), 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; CLR_ERR = 1'b0; OUT_READY = 1'b0; C_IN = '0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    chk("reset_err",  32'(ERR), 0);
    chk("reset_data", 32'(OUT_DATA), 0);
    chk("reset_row",  32'(OUT_ROW), 0);
    chk("reset_col",  32'(OUT_COL), 0);
    RST = 1'b0;

    // Ramp pattern 16r+c, full-rate then alternating ready.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = DW'(16 * r + c);
    run_stream(0, -1, 0, -1, 0);
    run_stream(1, -1, 0, -1, 0);

    // Input overwritten with all-ones right after capture.
    fill_random();
    run_stream(0, -1, 0, -1, 1);

    // START while busy sets ERR; clear; then set+clear together keeps ERR.
    run_stream(0, 5, 0, -1, 0);
    chk("err_sticky", 32'(ERR), 1);
    clear_err();
    fill_random();
    run_stream(2, 3, 1, -1, 0);
    chk("err_set_wins", 32'(ERR), 1);

    // Reset after five acceptances, then a clean full stream.
    run_stream(0, -1, 0, 5, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = DW'(16 * r + c);
    run_stream(0, -1, 0, -1, 0);

    // Corner extremes.
    fill_random();
    mat[0][0]     = 16'hFFFF;
    mat[N-1][N-1] = 16'h8000;
    run_stream(2, -1, 0, -1, 0);

    // Randomized streams with random backpressure.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_stream(2, -1, 0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
